stage_control_decoder: RTL and testbench
========================================

// Module: stage_control_decoder
// PURPOSE
//  Consumer end of the multicycle stage counter: samples the 1..5 ClockCount sequence, verifies it, and
//  issues registered one-hot stage strobes plus per-stage datapath control pulses gated by instruction type.
//  Sits between the clock counter and datapath in the control unit; also counts retired instructions.
// PARAMETERS
//  NSTAGE  5   stages per instruction; legal ClockCount values are 1..NSTAGE
//  CW      3   ClockCount width
//  ICNT_W  16  width of retired-instruction counter
// PORTS
//  Clock       in   1       rising-edge clock, shared with the clock counter
//  Reset       in   1       synchronous, active-high reset
//  ClockCount  in   CW      current stage number from the clock counter (1..NSTAGE)
//  InstrType   in   2       00 ALU, 01 LOAD, 10 STORE, 11 BRANCH; valid from stage 2
//  BranchTaken in   1       branch condition, sampled when stage 4 is issued
//  StageOH     out  NSTAGE  one-hot stage strobe; bit k-1 = stage k
//  IrLoad      out  1       stage 1: load instruction register
//  PcInc       out  1       stage 1: PC += 1
//  RegRead     out  1       stage 2: read register file
//  AluGo       out  1       stage 3: ALU operate
//  MemRead     out  1       stage 4 and type LOAD
//  MemWrite    out  1       stage 4 and type STORE
//  PcLoad      out  1       stage 4 and type BRANCH and BranchTaken
//  RegWrite    out  1       stage 5 and type ALU or LOAD
//  SeqError    out  1       1-cycle pulse on an illegal or out-of-order ClockCount
//  InstrCount  out  ICNT_W  retired instructions; wraps to 0 after all-ones
//  ErrCount    out  8       sequence-error count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset is synchronous, active-high and highest priority. It clears all outputs to 0,
//    sets state UNSYNC, clears the type latch to 00 and sets Prev to 0.
//  - All outputs are registered. Outputs for stage N appear in the cycle after the edge at which
//    ClockCount==N is sampled, giving a latency of 1 clock. Each strobe is high for exactly 1 cycle.
//  - Legal sample: 1 <= ClockCount <= NSTAGE. Expected value = (Prev==NSTAGE) ? 1 : Prev+1.
//  - FSM has 2 states:
//    UNSYNC:
//      * ClockCount==1 -> go to RUN and issue stage-1 strobes this edge.
//      * Any other legal value -> stay in UNSYNC, strobes 0, no error.
//      * Illegal value (0, 6, 7) -> SeqError pulse.
//    RUN:
//      * ClockCount==Expected -> issue stage strobes.
//      * Otherwise (illegal value or skip/repeat) -> SeqError pulse, all strobes 0 that cycle, go to UNSYNC.
//        A dropped instruction is not counted.
//  - Prev is updated with every sample, legal or not.
//  - InstrType is latched when stage 2 is issued in RUN. Stage 4/5 controls use the latched type,
//    so changes after stage 2 are ignored.
//  - BranchTaken is used combinationally at the stage-4 issue edge only.
//  - InstrCount increments when stage 5 is issued in RUN, and wraps modulo 2^ICNT_W.
//  - Reset mid-instruction: the next instruction starts only at the next ClockCount==1.
//    Partial instructions issue nothing further.
//  - Controls with type mismatch stay 0, e.g. MemRead stays 0 at stage 4 for ALU.
// CONFIGURATION
//  - Macro STAGE_DECODER_ERRCNT_EN:
//    * Defined: ErrCount increments on every SeqError pulse and saturates at 8'hFF. Cleared by Reset.
//    * Undefined: ErrCount is tied to 8'h00 and no counter logic is built.
//    * The port list is identical in both builds.
// TESTING
//  - Reset, then ClockCount 1,2,3,4,5 with type ALU -> StageOH 00001..10000 on successive cycles, each
//    1 cycle after its sample; IrLoad/PcInc, RegRead, AluGo and RegWrite fire; InstrCount=1.
//  - Type LOAD, then STORE, then BRANCH with BranchTaken=1/0 -> at stage 4 the bench sees:
//      * LOAD: MemRead=1 and RegWrite=1 at stage 5.
//      * STORE: MemWrite=1 and RegWrite=0.
//      * BRANCH taken: PcLoad=1; not taken: PcLoad=0.
//  - InstrType changed from LOAD to STORE at stage 3 -> stage 4 still gives MemRead=1 and MemWrite=0.
//  - Sequence 1,2,4 -> SeqError=1 for one cycle after 4 is sampled, no strobes. Then 5,1 -> no
//    strobes until 1, then stage-1 strobes resume; InstrCount unchanged.
//  - ClockCount=0 and 7 in RUN -> SeqError each time. With the macro defined ErrCount=2; undefined
//    ErrCount=0. With the macro defined and 300 errors, ErrCount=8'hFF.
//  - Reset asserted at stage 3 -> next edge all outputs 0 and state UNSYNC. A start at 4 gives no
//    strobes and no error until 1. Also preload InstrCount to 16'hFFFF and retire one -> 16'h0000.

Source files
------------

// File: rtl/stage_control_decoder.sv
// stage_control_decoder
//   Consumer end of the multicycle stage counter. Samples the 1..NSTAGE
//   ClockCount sequence, checks it against the expected successor, and issues
//   registered one-hot stage strobes plus datapath control pulses qualified by
//   the instruction type latched at stage 2. Also counts retired instructions.
//
// Optional feature: define STAGE_DECODER_ERRCNT_EN to build the saturating
//   sequence-error counter behind ErrCount; otherwise ErrCount is tied to 0.
//
// Ports
//   Clock       in   1       rising-edge clock
//   Reset       in   1       synchronous, active-high reset
//   ClockCount  in   CW      stage number from the clock counter (1..NSTAGE)
//   InstrType   in   2       00 ALU, 01 LOAD, 10 STORE, 11 BRANCH (valid from stage 2)
//   BranchTaken in   1       branch condition, used at the stage-4 issue edge
//   StageOH     out  NSTAGE  one-hot stage strobe, bit k-1 = stage k
//   IrLoad      out  1       stage 1: load instruction register
//   PcInc       out  1       stage 1: PC increment
//   RegRead     out  1       stage 2: register file read
//   AluGo       out  1       stage 3: ALU operate
//   MemRead     out  1       stage 4, LOAD
//   MemWrite    out  1       stage 4, STORE
//   PcLoad      out  1       stage 4, BRANCH and taken
//   RegWrite    out  1       stage 5, ALU or LOAD
//   SeqError    out  1       one-cycle pulse on illegal / out-of-order ClockCount
//   InstrCount  out  ICNT_W  retired instruction count (wraps)
//   ErrCount    out  8       saturating sequence-error count (feature build only)
module stage_control_decoder #(
   parameter int unsigned NSTAGE = 5,
   parameter int unsigned CW     = 3,
   parameter int unsigned ICNT_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [CW-1:0]     ClockCount,
   input  logic [1:0]        InstrType,
   input  logic              BranchTaken,
   output logic [NSTAGE-1:0] StageOH,
   output logic              IrLoad,
   output logic              PcInc,
   output logic              RegRead,
   output logic              AluGo,
   output logic              MemRead,
   output logic              MemWrite,
   output logic              PcLoad,
   output logic              RegWrite,
   output logic              SeqError,
   output logic [ICNT_W-1:0] InstrCount,
   output logic [7:0]        ErrCount
);

   localparam logic [1:0] TYPE_ALU    = 2'b00;
   localparam logic [1:0] TYPE_LOAD   = 2'b01;
   localparam logic [1:0] TYPE_STORE  = 2'b10;
   localparam logic [1:0] TYPE_BRANCH = 2'b11;

   localparam logic [CW-1:0] STAGE_FIRST = CW'(1);
   localparam logic [CW-1:0] STAGE_LAST  = CW'(NSTAGE);

   typedef enum logic {
      UNSYNC = 1'b0,
      RUN    = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       prev_q;
   logic [1:0]          type_q, type_d;
   logic [ICNT_W-1:0]   icnt_d;

   logic [CW-1:0]       expected;
   logic                legal;
   logic [CW-1:0]       issue;      // stage issued this edge, 0 = none
   logic [NSTAGE-1:0]   stage_oh_d;
   logic                ir_load_d, pc_inc_d, reg_read_d, alu_go_d;
   logic                mem_read_d, mem_write_d, pc_load_d, reg_write_d;
   logic                seq_err_d;

   // Sequence check, stage issue and control decode
   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      icnt_d      = InstrCount;
      issue       = '0;
      seq_err_d   = 1'b0;
      stage_oh_d  = '0;
      ir_load_d   = 1'b0;
      pc_inc_d    = 1'b0;
      reg_read_d  = 1'b0;
      alu_go_d    = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      pc_load_d   = 1'b0;
      reg_write_d = 1'b0;

      legal    = (ClockCount != '0) && (ClockCount <= STAGE_LAST);
      expected = (prev_q == STAGE_LAST) ? STAGE_FIRST : prev_q + STAGE_FIRST;

      unique case (state_q)
         UNSYNC: begin
            // Wait quietly for the start of an instruction; only illegal codes are errors
            if (!legal) begin
               seq_err_d = 1'b1;
            end else if (ClockCount == STAGE_FIRST) begin
               state_d = RUN;
               issue   = STAGE_FIRST;
            end
         end
         RUN: begin
            if (legal && (ClockCount == expected)) begin
               issue = ClockCount;
            end else begin
               seq_err_d = 1'b1;
               state_d   = UNSYNC;
            end
         end
         default: state_d = UNSYNC;
      endcase

      for (int unsigned k = 0; k < NSTAGE; k++) begin
         stage_oh_d[k] = (issue == CW'(k + 1));
      end

      ir_load_d  = (issue == CW'(1));
      pc_inc_d   = (issue == CW'(1));
      reg_read_d = (issue == CW'(2));
      alu_go_d   = (issue == CW'(3));

      // Stage 4/5 controls follow the type captured at stage 2, not the live input
      mem_read_d  = (issue == CW'(4)) && (type_q == TYPE_LOAD);
      mem_write_d = (issue == CW'(4)) && (type_q == TYPE_STORE);
      pc_load_d   = (issue == CW'(4)) && (type_q == TYPE_BRANCH) && BranchTaken;
      reg_write_d = (issue == CW'(5)) && ((type_q == TYPE_ALU) || (type_q == TYPE_LOAD));

      if (issue == CW'(2)) begin
         type_d = InstrType;
      end
      if (issue == STAGE_LAST) begin
         icnt_d = InstrCount + ICNT_W'(1);
      end
   end

   // State, history and registered outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= UNSYNC;
         prev_q     <= '0;
         type_q     <= TYPE_ALU;
         StageOH    <= '0;
         IrLoad     <= 1'b0;
         PcInc      <= 1'b0;
         RegRead    <= 1'b0;
         AluGo      <= 1'b0;
         MemRead    <= 1'b0;
         MemWrite   <= 1'b0;
         PcLoad     <= 1'b0;
         RegWrite   <= 1'b0;
         SeqError   <= 1'b0;
         InstrCount <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= ClockCount;
         type_q     <= type_d;
         StageOH    <= stage_oh_d;
         IrLoad     <= ir_load_d;
         PcInc      <= pc_inc_d;
         RegRead    <= reg_read_d;
         AluGo      <= alu_go_d;
         MemRead    <= mem_read_d;
         MemWrite   <= mem_write_d;
         PcLoad     <= pc_load_d;
         RegWrite   <= reg_write_d;
         SeqError   <= seq_err_d;
         InstrCount <= icnt_d;
      end
   end

`ifdef STAGE_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count of sequence errors
   always_ff @(posedge Clock) begin
      if (Reset) begin
         err_cnt_q <= 8'h00;
      end else if (seq_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign ErrCount = err_cnt_q;
`else
   assign ErrCount = 8'h00;
`endif

endmodule

// File: tb/tb_stage_control_decoder.sv
// Testbench for stage_control_decoder: directed scenarios followed by
// randomized ClockCount streams, checked against a behavioural model.
// A second instance with a 3-bit instruction counter exercises counter wrap.
module tb_stage_control_decoder;

   logic       Clock;
   logic       Reset;
   logic [2:0] ClockCount;
   logic [1:0] InstrType;
   logic       BranchTaken;

   logic [4:0]  StageOH;
   logic        IrLoad, PcInc, RegRead, AluGo, MemRead, MemWrite, PcLoad, RegWrite, SeqError;
   logic [15:0] InstrCount;
   logic [7:0]  ErrCount;

   logic [4:0]  s_StageOH;
   logic        s_IrLoad, s_PcInc, s_RegRead, s_AluGo, s_MemRead, s_MemWrite, s_PcLoad;
   logic        s_RegWrite, s_SeqError;
   logic [2:0]  s_InstrCount;
   logic [7:0]  s_ErrCount;

   stage_control_decoder dut (
      .Clock(Clock), .Reset(Reset), .ClockCount(ClockCount), .InstrType(InstrType),
      .BranchTaken(BranchTaken), .StageOH(StageOH), .IrLoad(IrLoad), .PcInc(PcInc),
      .RegRead(RegRead), .AluGo(AluGo), .MemRead(MemRead), .MemWrite(MemWrite),
      .PcLoad(PcLoad), .RegWrite(RegWrite), .SeqError(SeqError),
      .InstrCount(InstrCount), .ErrCount(ErrCount)
   );

   stage_control_decoder #(.ICNT_W(3)) dut_small (
      .Clock(Clock), .Reset(Reset), .ClockCount(ClockCount), .InstrType(InstrType),
      .BranchTaken(BranchTaken), .StageOH(s_StageOH), .IrLoad(s_IrLoad), .PcInc(s_PcInc),
      .RegRead(s_RegRead), .AluGo(s_AluGo), .MemRead(s_MemRead), .MemWrite(s_MemWrite),
      .PcLoad(s_PcLoad), .RegWrite(s_RegWrite), .SeqError(s_SeqError),
      .InstrCount(s_InstrCount), .ErrCount(s_ErrCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;

   // Reference model state (instruction-level view of the stream)
   bit in_instr   = 0;   // currently following an instruction
   int last_cc    = 0;   // previous sample, legal or not
   int cur_type   = 0;   // type captured at stage 2
   int retired    = 0;   // total instructions retired since reset
   int seq_errs   = 0;   // total sequence errors since reset
   int drv_cc     = 0;   // last value driven in the random section

   logic [4:0]  e_oh;
   logic [8:0]  e_ctrl;
   logic [15:0] e_icnt;
   logic [2:0]  e_icnt_small;
   logic [7:0]  e_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive one sample, advance the model, clock, then compare all outputs
   task automatic step(input int cc, input int it, input int bt, input bit rst);
      int stage;
      bit err;
      Reset       = rst;
      ClockCount  = 3'(cc);
      InstrType   = 2'(it);
      BranchTaken = 1'(bt);

      stage = 0;
      err   = 0;
      if (rst) begin
         in_instr = 0;
         last_cc  = 0;
         cur_type = 0;
         retired  = 0;
         seq_errs = 0;
      end else begin
         if (cc < 1 || cc > 5) begin
            err      = 1;
            in_instr = 0;
         end else if (!in_instr) begin
            if (cc == 1) begin
               in_instr = 1;
               stage    = 1;
            end
         end else if (cc == (last_cc % 5) + 1) begin
            stage = cc;
         end else begin
            err      = 1;
            in_instr = 0;
         end
         last_cc = cc;
      end

      e_oh   = (stage == 0) ? 5'd0 : 5'(1 << (stage - 1));
      e_ctrl = {stage == 1, stage == 1, stage == 2, stage == 3,
                stage == 4 && cur_type == 1,
                stage == 4 && cur_type == 2,
                stage == 4 && cur_type == 3 && bt != 0,
                stage == 5 && (cur_type == 0 || cur_type == 1),
                err};
      if (stage == 2) cur_type = it;
      if (stage == 5) retired++;
      if (err) seq_errs++;
      e_icnt       = 16'(retired % 65536);
      e_icnt_small = 3'(retired % 8);
`ifdef STAGE_DECODER_ERRCNT_EN
      e_err = (seq_errs > 255) ? 8'hFF : 8'(seq_errs);
`else
      e_err = 8'h00;
`endif

      @(posedge Clock);
      #1;
      chk("stage_oh", 64'(StageOH), 64'(e_oh));
      chk("controls", 64'({IrLoad, PcInc, RegRead, AluGo, MemRead, MemWrite, PcLoad, RegWrite, SeqError}),
          64'(e_ctrl));
      chk("instr_count", 64'(InstrCount), 64'(e_icnt));
      chk("err_count", 64'(ErrCount), 64'(e_err));
      chk("instr_count_small", 64'(s_InstrCount), 64'(e_icnt_small));
   endtask

   task automatic instr(input int it, input int bt);
      for (int s = 1; s <= 5; s++) step(s, it, bt, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; ClockCount = '0; InstrType = '0; BranchTaken = 1'b0;

      // Reset state
      step(0, 0, 0, 1'b1);
      step(3, 0, 0, 1'b1);

      // ALU, LOAD, STORE, BRANCH taken / not taken
      instr(0, 0);
      chk("alu_retired", 64'(InstrCount), 64'd1);
      instr(1, 0);
      instr(2, 1);
      instr(3, 1);
      instr(3, 0);

      // Type changes from LOAD to STORE after stage 2 are ignored
      step(1, 1, 0, 1'b0);
      step(2, 1, 0, 1'b0);
      step(3, 2, 0, 1'b0);
      step(4, 2, 0, 1'b0);
      chk("late_type_memread", 64'({MemRead, MemWrite}), 64'b10);
      step(5, 2, 0, 1'b0);

      // Skip 1,2,4 then 5 (no error) and a fresh instruction from 1
      step(1, 0, 0, 1'b0);
      step(2, 0, 0, 1'b0);
      step(4, 0, 0, 1'b0);
      chk("skip_error", 64'({SeqError, StageOH}), 64'({1'b1, 5'b0}));
      step(5, 0, 0, 1'b0);
      instr(1, 0);

      // Illegal 0 and 7 while running
      step(1, 0, 0, 1'b0);
      step(2, 0, 0, 1'b0);
      step(0, 0, 0, 1'b0);
      step(1, 0, 0, 1'b0);
      step(7, 0, 0, 1'b0);
      chk("illegal_pulse", 64'(SeqError), 64'd1);

      // Reset during stage 3, restart at 4 is ignored until a 1
      step(1, 0, 0, 1'b0);
      step(2, 0, 0, 1'b0);
      step(3, 0, 0, 1'b0);
      step(4, 0, 0, 1'b1);
      step(4, 0, 0, 1'b0);
      step(5, 0, 0, 1'b0);
      instr(1, 0);

      // Error counter saturation with a long run of illegal codes
      for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 0 : 6, 0, 0, 1'b0);

      // Retire enough instructions to wrap the 3-bit counter twice
      for (int i = 0; i < 17; i++) instr(i % 4, i % 2);

      // Randomized stream: mostly well-ordered, with corrupt codes and resets
      step(0, 0, 0, 1'b1);
      drv_cc = 0;
      for (int i = 0; i < 600; i++) begin
         int r, cc;
         bit rst;
         r   = $urandom_range(0, 99);
         rst = (r < 2);
         if (r < 14) cc = $urandom_range(0, 7);
         else        cc = (drv_cc >= 1 && drv_cc <= 4) ? drv_cc + 1 : 1;
         step(cc, $urandom_range(0, 3), $urandom_range(0, 1), rst);
         drv_cc = rst ? 0 : cc;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
